ring_router_mux: RTL and testbench

Merges two DI worm streams, ring pass-through traffic and locally injected traffic, onto a router's single ring output. It sits directly downstream of the router's ring/local demux, taking its ring-side output, and alongside the local injection port. Arbitration is packet-granular: once a worm wins, it owns the output until its last flit. A 2-entry output buffer cuts every combinational path from `out.ready` to the inputs while sustaining 1 flit/cycle.

---
 rtl/ring_router_mux_pkg.sv | 26 ++
 rtl/ring_router_mux_dii_buffer_2.sv | 56 +++++
 rtl/ring_router_mux.sv | 107 ++++++++++
 tb/tb_ring_router_mux.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_router_mux_pkg.sv
// Shared definitions for the ring router output merge: DI channel payload,
// flit geometry and arbiter state encoding.
package ring_router_mux_pkg;

    localparam int unsigned FLIT_W = 16;
    // Destination id occupies bits [DEST_W-1:0] of the first flit of a worm.
    localparam int unsigned DEST_W = 10;

    // DI channel: payload plus valid forward, ready travels back separately.
    typedef struct packed {
        logic [FLIT_W-1:0] data;
        logic              last;
    } dii_flit_t;

    typedef struct packed {
        dii_flit_t flit;
        logic      valid;
    } dii_fwd_t;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE       = 2'd0;
    localparam arb_state_t ST_LOCK_RING  = 2'd1;
    localparam arb_state_t ST_LOCK_LOCAL = 2'd2;

endpackage

// File: rtl/ring_router_mux_dii_buffer_2.sv
// Two-entry {data,last} FIFO with valid/ready on both sides. Input ready
// depends only on the occupancy register, so no path exists from i_ready.
module dii_buffer_2
    import ring_router_mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [FLIT_W-1:0] o_data,
    output logic              o_last,
    output logic              o_valid,
    input  logic              i_ready
);

    dii_flit_t  r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr].data;
    assign o_last  = r_mem[r_rd_ptr].last;

    assign w_push = i_valid & o_ready;
    assign w_pop  = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{data: i_data, last: i_last};
        end
    end

endmodule

// File: rtl/ring_router_mux.sv
// Packet-granular merge of ring pass-through and local injection worms onto
// the router's ring output, decoupled through a 2-entry output buffer.
module ring_router_mux
    import ring_router_mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] i_in_ring_data,
    input  logic              i_in_ring_last,
    input  logic              i_in_ring_valid,
    output logic              o_in_ring_ready,
    input  logic [FLIT_W-1:0] i_in_local_data,
    input  logic              i_in_local_last,
    input  logic              i_in_local_valid,
    output logic              o_in_local_ready,
    output logic [FLIT_W-1:0] o_out_ring_data,
    output logic              o_out_ring_last,
    output logic              o_out_ring_valid,
    input  logic              i_out_ring_ready
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_prio;
    logic              w_prio_next;
    logic              w_grant_ring;
    logic              w_grant_local;
    logic              w_buf_ready;
    logic              w_push_valid;
    logic [FLIT_W-1:0] w_push_data;
    logic              w_push_last;
    logic              w_xfer;

    always_comb begin
        w_grant_ring  = 1'b0;
        w_grant_local = 1'b0;
        case (r_state)
            ST_LOCK_RING:  w_grant_ring  = 1'b1;
            ST_LOCK_LOCAL: w_grant_local = 1'b1;
            default: begin
                if (i_in_ring_valid && i_in_local_valid) begin
                    w_grant_local = r_prio;
                    w_grant_ring  = ~r_prio;
                end else begin
                    w_grant_ring  = i_in_ring_valid;
                    w_grant_local = i_in_local_valid;
                end
            end
        endcase
    end

    assign o_in_ring_ready  = w_grant_ring & w_buf_ready;
    assign o_in_local_ready = w_grant_local & w_buf_ready;

    always_comb begin
        w_push_valid = 1'b0;
        w_push_data  = i_in_ring_data;
        w_push_last  = i_in_ring_last;
        if (w_grant_ring) begin
            w_push_valid = i_in_ring_valid;
        end else if (w_grant_local) begin
            w_push_valid = i_in_local_valid;
            w_push_data  = i_in_local_data;
            w_push_last  = i_in_local_last;
        end
    end

    assign w_xfer = w_push_valid & w_buf_ready;

    // A finished worm hands preference to the other input.
    always_comb begin
        w_state_next = r_state;
        w_prio_next  = r_prio;
        if (w_xfer) begin
            if (w_push_last) begin
                w_state_next = ST_IDLE;
                w_prio_next  = w_grant_ring;
            end else begin
                w_state_next = w_grant_ring ? ST_LOCK_RING : ST_LOCK_LOCAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_prio  <= w_prio_next;
        end
    end

    dii_buffer_2 u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .i_data  (w_push_data),
        .i_last  (w_push_last),
        .i_valid (w_push_valid),
        .o_ready (w_buf_ready),
        .o_data  (o_out_ring_data),
        .o_last  (o_out_ring_last),
        .o_valid (o_out_ring_valid),
        .i_ready (i_out_ring_ready)
    );

endmodule

// File: tb/tb_ring_router_mux.sv
// Bench for ring_router_mux: a worm-level reference model (owner, preference,
// queue of buffered flits) predicts ready/valid/data every cycle.
module tb_ring_router_mux;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } tflit_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_in_ring_data;
    logic        i_in_ring_last;
    logic        i_in_ring_valid;
    logic        o_in_ring_ready;
    logic [15:0] i_in_local_data;
    logic        i_in_local_last;
    logic        i_in_local_valid;
    logic        o_in_local_ready;
    logic [15:0] o_out_ring_data;
    logic        o_out_ring_last;
    logic        o_out_ring_valid;
    logic        i_out_ring_ready;

    always #5 clk = ~clk;

    ring_router_mux dut (
        .clk              (clk),
        .rst              (rst),
        .i_in_ring_data   (i_in_ring_data),
        .i_in_ring_last   (i_in_ring_last),
        .i_in_ring_valid  (i_in_ring_valid),
        .o_in_ring_ready  (o_in_ring_ready),
        .i_in_local_data  (i_in_local_data),
        .i_in_local_last  (i_in_local_last),
        .i_in_local_valid (i_in_local_valid),
        .o_in_local_ready (o_in_local_ready),
        .o_out_ring_data  (o_out_ring_data),
        .o_out_ring_last  (o_out_ring_last),
        .o_out_ring_valid (o_out_ring_valid),
        .i_out_ring_ready (i_out_ring_ready)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: 0 = none, 1 = ring, 2 = local.
    int     owner = 0;
    int     pref  = 0;
    tflit_t mq[$];

    tflit_t ring_src[$], local_src[$], ring_exp[$], local_exp[$], obs[$];
    int     obs_cyc[$];
    int     ring_p = 100, local_p = 100, local_gap = 0;

    task automatic drive_ring();
        if (!i_in_ring_valid && ring_src.size() > 0 && $urandom_range(0, 99) < ring_p) begin
            i_in_ring_valid = 1'b1;
            i_in_ring_data  = ring_src[0].d;
            i_in_ring_last  = ring_src[0].l;
        end
    endtask

    task automatic drive_local();
        if (!i_in_local_valid && local_src.size() > 0) begin
            if (local_gap > 0) begin
                local_gap--;
            end else if ($urandom_range(0, 99) < local_p) begin
                i_in_local_valid = 1'b1;
                i_in_local_data  = local_src[0].d;
                i_in_local_last  = local_src[0].l;
            end
        end
    endtask

    task automatic cycle();
        int     g;
        bit     full, er, el, ev, rv, lv, orr;
        tflit_t rf, lf;
        #1;
        rv   = i_in_ring_valid;
        lv   = i_in_local_valid;
        orr  = i_out_ring_ready;
        rf   = {i_in_ring_data, i_in_ring_last};
        lf   = {i_in_local_data, i_in_local_last};
        full = (mq.size() == 2);
        if (owner != 0)    g = owner;
        else if (rv && lv) g = (pref != 0) ? 2 : 1;
        else if (rv)       g = 1;
        else if (lv)       g = 2;
        else               g = 0;
        er = (g == 1) && !full;
        el = (g == 2) && !full;
        ev = (mq.size() != 0);
        n_cmp += 3;
        if (o_in_ring_ready !== er) begin
            n_fail++;
            $display("FAIL ring_ready cyc=%0d got=%b exp=%b", cyc, o_in_ring_ready, er);
        end
        if (o_in_local_ready !== el) begin
            n_fail++;
            $display("FAIL local_ready cyc=%0d got=%b exp=%b", cyc, o_in_local_ready, el);
        end
        if (o_out_ring_valid !== ev) begin
            n_fail++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, o_out_ring_valid, ev);
        end
        if (ev) begin
            n_cmp++;
            if ({o_out_ring_data, o_out_ring_last} !== mq[0]) begin
                n_fail++;
                $display("FAIL out_flit cyc=%0d got=%h/%b exp=%h/%b", cyc,
                         o_out_ring_data, o_out_ring_last, mq[0].d, mq[0].l);
            end
        end
        if (o_out_ring_valid === 1'b1 && orr) begin
            obs.push_back({o_out_ring_data, o_out_ring_last});
            obs_cyc.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            owner = 0;
            pref  = 0;
        end else begin
            if (ev && orr) void'(mq.pop_front());
            if ((er && rv) || (el && lv)) begin
                tflit_t f;
                f = er ? rf : lf;
                mq.push_back(f);
                if (f.l) begin
                    owner = 0;
                    pref  = (g == 1) ? 1 : 0;
                end else begin
                    owner = g;
                end
                if (er) void'(ring_src.pop_front());
                else    void'(local_src.pop_front());
            end
        end
        #1;
        if (!rst && er && rv) i_in_ring_valid = 1'b0;
        if (!rst && el && lv) i_in_local_valid = 1'b0;
        drive_ring();
        drive_local();
    endtask

    task automatic run(input int max, input bit rnd_out);
        int n = 0;
        while ((ring_src.size() > 0 || local_src.size() > 0 || mq.size() > 0) && n < max) begin
            if (rnd_out) i_out_ring_ready = ($urandom_range(0, 3) != 0);
            cycle();
            n++;
        end
        i_out_ring_ready = 1'b1;
        n_cmp++;
        if (n >= max) begin
            n_fail++;
            $display("FAIL drain_timeout got=%0d cycles exp=<%0d", n, max);
        end
    endtask

    task automatic add_worm(input bit loc, input int len, input bit tag);
        for (int i = 0; i < len; i++) begin
            tflit_t      f;
            logic [31:0] r;
            r   = $urandom();
            f.d = {tag, r[14:0]};
            f.l = (i == len - 1);
            if (loc) begin
                local_src.push_back(f);
                local_exp.push_back(f);
            end else begin
                ring_src.push_back(f);
                ring_exp.push_back(f);
            end
        end
    endtask

    task automatic do_reset();
        i_in_ring_valid  = 1'b0;
        i_in_local_valid = 1'b0;
        ring_src.delete();
        local_src.delete();
        ring_exp.delete();
        local_exp.delete();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        obs.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        i_in_ring_valid  = 1'b0;
        i_in_local_valid = 1'b0;
        i_in_ring_data   = '0;
        i_in_ring_last   = 1'b0;
        i_in_local_data  = '0;
        i_in_local_last  = 1'b0;
        i_out_ring_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 3;
        if (o_out_ring_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid got=%b exp=0", o_out_ring_valid);
        end
        if (o_in_ring_ready !== 1'b0 || o_in_local_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready got=%b%b exp=00", o_in_ring_ready, o_in_local_ready);
        end
        i_in_ring_valid = 1'b1;
        #1;
        if (o_in_ring_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_grant got=%b exp=1", o_in_ring_ready);
        end
        i_in_ring_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_ring_worm();
        tflit_t exp_f[3];
        int     c0;
        do_reset();
        exp_f[0] = {16'h0005, 1'b0};
        exp_f[1] = {16'h1111, 1'b0};
        exp_f[2] = {16'h2222, 1'b1};
        for (int i = 0; i < 3; i++) ring_src.push_back(exp_f[i]);
        drive_ring();
        c0 = cyc;
        run(20, 1'b0);
        n_cmp++;
        if (obs.size() != 3) begin
            n_fail++;
            $display("FAIL ring_worm_count got=%0d exp=3", obs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (obs[i] !== exp_f[i] || obs_cyc[i] != c0 + 1 + i) begin
                    n_fail++;
                    $display("FAIL ring_worm_flit%0d got=%h/%b@%0d exp=%h/%b@%0d", i, obs[i].d,
                             obs[i].l, obs_cyc[i], exp_f[i].d, exp_f[i].l, c0 + 1 + i);
                end
            end
        end
    endtask

    task automatic test_contention();
        do_reset();
        add_worm(1'b0, 4, 1'b0);
        add_worm(1'b1, 4, 1'b1);
        drive_ring();
        drive_local();
        run(40, 1'b0);
        n_cmp++;
        if (obs.size() != 8) begin
            n_fail++;
            $display("FAIL contention_count got=%0d exp=8", obs.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tflit_t e;
                e = (i < 4) ? ring_exp[i] : local_exp[i - 4];
                n_cmp++;
                if (obs[i] !== e) begin
                    n_fail++;
                    $display("FAIL contention_flit%0d got=%h exp=%h", i, obs[i].d, e.d);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            add_worm(1'b0, 1, 1'b0);
            add_worm(1'b1, 1, 1'b1);
        end
        drive_ring();
        drive_local();
        run(60, 1'b0);
        n_cmp++;
        if (obs.size() != 24) begin
            n_fail++;
            $display("FAIL alternate_count got=%0d exp=24", obs.size());
        end else begin
            for (int i = 0; i < 24; i++) begin
                tflit_t e;
                e = (i % 2 == 0) ? ring_exp[i / 2] : local_exp[i / 2];
                n_cmp++;
                if (obs[i] !== e || obs_cyc[i] != obs_cyc[0] + i) begin
                    n_fail++;
                    $display("FAIL alternate_flit%0d got=%h@%0d exp=%h@%0d", i, obs[i].d,
                             obs_cyc[i], e.d, obs_cyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        add_worm(1'b0, 6, 1'b0);
        drive_ring();
        cycle();
        cycle();
        i_out_ring_ready = 1'b0;
        repeat (5) cycle();
        #1;
        n_cmp++;
        if (o_in_ring_ready !== 1'b0 || o_out_ring_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_full got=rdy%b/vld%b exp=rdy0/vld1", o_in_ring_ready,
                     o_out_ring_valid);
        end
        i_out_ring_ready = 1'b1;
        run(30, 1'b0);
        n_cmp++;
        if (obs.size() != 6) begin
            n_fail++;
            $display("FAIL stall_count got=%0d exp=6", obs.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (obs[i] !== ring_exp[i]) begin
                    n_fail++;
                    $display("FAIL stall_flit%0d got=%h exp=%h", i, obs[i].d, ring_exp[i].d);
                end
            end
        end
    endtask

    task automatic test_lock_hold();
        do_reset();
        add_worm(1'b1, 4, 1'b1);
        drive_local();
        local_gap = 3;
        cycle();
        add_worm(1'b0, 2, 1'b0);
        drive_ring();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (o_in_ring_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_ring_blocked step%0d got=%b exp=0", i, o_in_ring_ready);
            end
            cycle();
        end
        run(30, 1'b0);
        n_cmp++;
        if (obs.size() != 6) begin
            n_fail++;
            $display("FAIL lock_count got=%0d exp=6", obs.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tflit_t e;
                e = (i < 4) ? local_exp[i] : ring_exp[i - 4];
                n_cmp++;
                if (obs[i] !== e) begin
                    n_fail++;
                    $display("FAIL lock_flit%0d got=%h exp=%h", i, obs[i].d, e.d);
                end
            end
            n_cmp++;
            if (obs_cyc[4] != obs_cyc[3] + 1) begin
                n_fail++;
                $display("FAIL lock_no_bubble got=%0d exp=%0d", obs_cyc[4], obs_cyc[3] + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_out_ring_ready = 1'b0;
        add_worm(1'b1, 5, 1'b1);
        drive_local();
        repeat (4) cycle();
        i_in_local_valid = 1'b0;
        local_src.delete();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        i_out_ring_ready = 1'b1;
        n_cmp++;
        if (o_out_ring_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_out_valid got=%b exp=0", o_out_ring_valid);
        end
        ring_exp.delete();
        local_exp.delete();
        add_worm(1'b0, 1, 1'b0);
        add_worm(1'b1, 1, 1'b1);
        drive_ring();
        drive_local();
        #1;
        n_cmp++;
        if (o_in_ring_ready !== 1'b1 || o_in_local_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_idle_prio got=%b%b exp=10", o_in_ring_ready, o_in_local_ready);
        end
        run(20, 1'b0);
    endtask

    task automatic test_random();
        int i = 0;
        i_in_ring_valid  = 1'b0;
        i_in_local_valid = 1'b0;
        ring_exp.delete();
        local_exp.delete();
        obs.delete();
        obs_cyc.delete();
        ring_p  = 60;
        local_p = 60;
        for (int w = 0; w < 30; w++) begin
            add_worm(1'b0, $urandom_range(1, 4), 1'b0);
            add_worm(1'b1, $urandom_range(1, 4), 1'b1);
        end
        drive_ring();
        drive_local();
        run(3000, 1'b1);
        ring_p  = 100;
        local_p = 100;
        while (i < obs.size()) begin
            bit     src, done;
            tflit_t e;
            src  = obs[i].d[15];
            done = 1'b0;
            while (!done && i < obs.size()) begin
                n_cmp++;
                if ((src ? local_exp.size() : ring_exp.size()) == 0) begin
                    n_fail++;
                    $display("FAIL random_extra got=%h exp=none", obs[i].d);
                    return;
                end
                e = src ? local_exp.pop_front() : ring_exp.pop_front();
                if (obs[i] !== e) begin
                    n_fail++;
                    $display("FAIL random_flit%0d got=%h/%b exp=%h/%b", i, obs[i].d, obs[i].l,
                             e.d, e.l);
                end
                done = e.l;
                i++;
            end
        end
        n_cmp++;
        if (ring_exp.size() != 0 || local_exp.size() != 0) begin
            n_fail++;
            $display("FAIL random_missing got=%0d/%0d exp=0/0", ring_exp.size(),
                     local_exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_ring_worm();
        test_contention();
        test_back_to_back();
        test_stall();
        test_lock_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
